// File: rtl/uart_rx_frame_ctrl.sv
// Frames UART bytes (header, length, payload, checksum) into a checked payload buffer.
// Latency: frame_valid / err_* one cycle after the deciding rx_done; rd_data one cycle after rd_addr.
// No backpressure: bytes arriving while a frame is held are dropped and flagged as overrun.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 13020
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       frame_valid,
  output logic [7:0] frame_len,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       frame_ack,
  output logic       busy,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int          AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_L8  = 8'(MAX_LEN);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, HOLD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_q;
  logic [7:0]  sum_q;
  logic [7:0]  idx_q;
  logic [15:0] to_cnt_q;
  logic [7:0]  pay_mem [0:MAX_LEN-1];

  logic timed, to_fire;
  logic load_len, pay_we, set_vld, clr_vld;
  logic e_chk, e_len, e_ovr;

  assign timed = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
  // A byte landing on the final count wins over the timeout.
  assign to_fire = timed && !rx_done && (to_cnt_q == TO_LAST);
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    load_len = 1'b0;
    pay_we   = 1'b0;
    set_vld  = 1'b0;
    clr_vld  = 1'b0;
    e_chk    = 1'b0;
    e_len    = 1'b0;
    e_ovr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_done && rx_data == HEADER) state_d = LEN;
      end
      LEN: begin
        if (rx_done) begin
          if (rx_data != 8'd0 && rx_data <= MAX_L8) begin
            load_len = 1'b1;
            state_d  = PAYLOAD;
          end else begin
            e_len   = 1'b1;
            state_d = IDLE;
          end
        end else if (to_fire) begin
          state_d = IDLE;
        end
      end
      PAYLOAD: begin
        if (rx_done) begin
          pay_we = 1'b1;
          if (idx_q == len_q - 8'd1) state_d = CHK;
        end else if (to_fire) begin
          state_d = IDLE;
        end
      end
      CHK: begin
        if (rx_done) begin
          if (rx_data == sum_q) begin
            set_vld = 1'b1;
            state_d = HOLD;
          end else begin
            e_chk   = 1'b1;
            state_d = IDLE;
          end
        end else if (to_fire) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        e_ovr = rx_done;
        if (frame_ack) begin
          clr_vld = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= 8'd0;
      sum_q       <= 8'd0;
      idx_q       <= 8'd0;
      to_cnt_q    <= 16'd0;
      frame_valid <= 1'b0;
      frame_len   <= 8'd0;
      rd_data     <= 8'd0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_len) begin
        len_q <= rx_data;
        sum_q <= rx_data;
        idx_q <= 8'd0;
      end else if (pay_we) begin
        sum_q <= sum_q + rx_data;
        idx_q <= idx_q + 8'd1;
      end
      if (rx_done || !timed) to_cnt_q <= 16'd0;
      else                   to_cnt_q <= to_cnt_q + 16'd1;
      if (set_vld) begin
        frame_valid <= 1'b1;
        frame_len   <= len_q;
      end else if (clr_vld) begin
        frame_valid <= 1'b0;
      end
      // frame_len never exceeds MAX_LEN, so an in-range address also fits the buffer.
      if (rd_addr < frame_len) rd_data <= pay_mem[rd_addr[AW-1:0]];
      else                     rd_data <= 8'd0;
      err_chk     <= e_chk;
      err_len     <= e_len;
      err_timeout <= to_fire;
      err_overrun <= e_ovr;
    end
  end

  always_ff @(posedge sysclk) begin
    if (pay_we) pay_mem[idx_q[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: good/bad frames, length, timeout, overrun, reset.
module tb_uart_rx_frame_ctrl;

  localparam int TO = 13020;

  logic       sysclk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_valid;
  logic [7:0] frame_len;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_ack;
  logic       busy;
  logic       err_chk, err_len, err_timeout, err_overrun;

  int n_assert = 0;
  int n_fail   = 0;
  int c_chk = 0, c_len = 0, c_to = 0, c_ovr = 0;

  uart_rx_frame_ctrl #(.HEADER(8'hA5), .MAX_LEN(16), .TIMEOUT_CYC(TO)) dut (
    .sysclk(sysclk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .frame_valid(frame_valid), .frame_len(frame_len), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_ack(frame_ack), .busy(busy),
    .err_chk(err_chk), .err_len(err_len), .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 sysclk = ~sysclk;

  // Pulse counters: each error must add exactly one per event.
  always @(negedge sysclk) begin
    c_chk += int'(err_chk);
    c_len += int'(err_len);
    c_to  += int'(err_timeout);
    c_ovr += int'(err_overrun);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    rd_addr = a;
    tick(1);
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick(1);
    frame_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; rd_addr = 8'h00; frame_ack = 1'b0;
    tick(3);
    chk("rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_len",   {24'd0, frame_len},   32'd0);
    chk("rst_rd",    {24'd0, rd_data},     32'd0);
    chk("rst_busy",  {31'd0, busy},        32'd0);
    chk("rst_errs",  {28'd0, err_chk, err_len, err_timeout, err_overrun}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Good frame A5 03 11 22 33 69
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22);
    send(8'h33);
    chk("good_not_yet", {31'd0, frame_valid}, 32'd0);
    send(8'h69);
    chk("good_valid", {31'd0, frame_valid}, 32'd1);
    chk("good_len",   {24'd0, frame_len},   32'd3);
    chk("good_busy",  {31'd0, busy},        32'd1);
    rd(8'd0, 8'h11, "good_rd0");
    rd(8'd1, 8'h22, "good_rd1");
    rd(8'd2, 8'h33, "good_rd2");
    rd(8'd3, 8'h00, "good_rd_oob");
    ack();
    chk("good_ack_valid", {31'd0, frame_valid}, 32'd0);
    chk("good_ack_busy",  {31'd0, busy},        32'd0);

    // Bad checksum A5 02 10 20 00, then A5 01 7F 80
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    chk("badchk_pulse", {31'd0, err_chk},     32'd1);
    chk("badchk_valid", {31'd0, frame_valid}, 32'd0);
    chk("badchk_busy",  {31'd0, busy},        32'd0);
    tick(1);
    chk("badchk_width", {31'd0, err_chk}, 32'd0);
    chk("badchk_count", c_chk, 32'd1);
    send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
    chk("one_valid", {31'd0, frame_valid}, 32'd1);
    chk("one_len",   {24'd0, frame_len},   32'd1);
    rd(8'd0, 8'h7F, "one_rd0");
    ack();

    // Length errors: 0 and MAX_LEN+1
    send(8'hA5); send(8'h00);
    chk("len0_pulse", {31'd0, err_len}, 32'd1);
    chk("len0_busy",  {31'd0, busy},    32'd0);
    send(8'hA5); send(8'h11);
    chk("len17_pulse", {31'd0, err_len}, 32'd1);
    tick(1);
    chk("len_count", c_len, 32'd2);

    // Maximum length: payload 00..0F, checksum 10+78 = 88
    send(8'hA5); send(8'h10);
    for (int i = 0; i < 16; i++) send(8'(i));
    send(8'h88);
    chk("max_valid", {31'd0, frame_valid}, 32'd1);
    chk("max_len",   {24'd0, frame_len},   32'd16);
    rd(8'd15, 8'h0F, "max_rd15");
    rd(8'd16, 8'h00, "max_rd16");

    // Overrun while held: four bytes dropped, data untouched
    send(8'hA5); send(8'h01); send(8'h55); send(8'h56);
    tick(1);
    chk("ovr_count", c_ovr, 32'd4);
    chk("ovr_valid", {31'd0, frame_valid}, 32'd1);
    rd(8'd0, 8'h00, "ovr_rd0");
    rd(8'd5, 8'h05, "ovr_rd5");

    // Ack and header byte in the same cycle
    frame_ack = 1'b1; rx_data = 8'hA5; rx_done = 1'b1;
    tick(1);
    frame_ack = 1'b0; rx_done = 1'b0;
    chk("coll_valid", {31'd0, frame_valid}, 32'd0);
    chk("coll_ovr",   {31'd0, err_overrun}, 32'd1);
    chk("coll_busy",  {31'd0, busy},        32'd0);
    tick(1);
    chk("coll_count", c_ovr, 32'd5);

    // Timeout after A5 04 01
    send(8'hA5); send(8'h04); send(8'h01);
    tick(TO - 1);
    chk("to_early",      {31'd0, err_timeout}, 32'd0);
    chk("to_early_busy", {31'd0, busy},        32'd1);
    tick(1);
    chk("to_pulse", {31'd0, err_timeout}, 32'd1);
    chk("to_busy",  {31'd0, busy},        32'd0);
    tick(1);
    chk("to_width", {31'd0, err_timeout}, 32'd0);

    // Gap of TO-1 cycles is tolerated: A5 04 01 .. 02 03 04 0E
    send(8'hA5); send(8'h04); send(8'h01);
    tick(TO - 1);
    send(8'h02); send(8'h03); send(8'h04); send(8'h0E);
    chk("gap_valid", {31'd0, frame_valid}, 32'd1);
    chk("gap_len",   {24'd0, frame_len},   32'd4);
    chk("gap_tocnt", c_to, 32'd1);
    rd(8'd3, 8'h04, "gap_rd3");
    ack();

    // Reset mid-frame
    rd_addr = 8'd0;
    send(8'hA5); send(8'h03); send(8'h11);
    tick(1);
    chk("pre_rst_rd", {24'd0, rd_data}, 32'h11);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy},      32'd0);
    chk("mid_rst_len",  {24'd0, frame_len}, 32'd0);
    chk("mid_rst_rd",   {24'd0, rd_data},   32'd0);
    tick(1);
    rst = 1'b0;
    send(8'h22); send(8'h33); send(8'h69);
    tick(1);
    chk("post_rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("post_rst_busy",  {31'd0, busy},        32'd0);
    chk("post_rst_errs",  c_chk + c_len + c_to + c_ovr, 32'd9);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    chk("fresh_valid", {31'd0, frame_valid}, 32'd1);
    rd(8'd2, 8'h33, "fresh_rd2");
    ack();
    chk("fresh_ack", {31'd0, frame_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

- Sequences the byte stream from the UART receiver (`Data`/`rx_done`) into checked command frames.
- Frame format: header byte, length byte, payload, 8-bit checksum.
- Buffers the payload and holds it for a downstream consumer until acknowledged.
- Flags checksum, length, timeout and overrun errors.
- Sits between the UART receiver and the command decoder.

## Interface
- `HEADER`, 8'hA5, frame start byte.
- `MAX_LEN`, 16, maximum payload bytes (1..255); sets buffer depth.
- `TIMEOUT_CYC`, 13020, max `sysclk` cycles between bytes inside a frame (about 3 byte-times at 115200 baud, 50 MHz).

Ports:
- `sysclk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: received byte, valid when `rx_done`=1.
- `rx_done` in 1: one-cycle strobe per received byte.
- `frame_valid` out 1: level; checked frame is held in the buffer.
- `frame_len` out 8: payload length of held frame; valid while `frame_valid`.
- `rd_addr` in 8: payload read index, 0..`frame_len`-1.
- `rd_data` out 8: registered payload byte at `rd_addr`.
- `frame_ack` in 1: one-cycle pulse; consumer is done with the held frame.
- `busy` out 1: high in any state except IDLE.
- `err_chk` out 1: one-cycle pulse; checksum mismatch.
- `err_len` out 1: one-cycle pulse; length 0 or greater than `MAX_LEN`.
- `err_timeout` out 1: one-cycle pulse; inter-byte timeout inside a frame.
- `err_overrun` out 1: one-cycle pulse; byte arrived while in HOLD.

## Operation
States: IDLE, LEN, PAYLOAD, CHK, HOLD. Only `rx_done` cycles advance the FSM; bytes are sampled on the `rx_done` cycle.

- **IDLE**
  - `rx_data`==`HEADER` -> LEN. Any other byte is ignored, with no error.
- **LEN**
  - A byte L with 1<=L<=`MAX_LEN`: latch L, clear `sum`<=L, clear `idx`<=0, -> PAYLOAD.
  - Otherwise: pulse `err_len`, -> IDLE.
- **PAYLOAD**
  - Each byte: `buf[idx]`<=byte, `sum`<=`sum`+byte (mod 256), `idx`<=`idx`+1.
  - The byte written at `idx`==L-1 -> CHK.
- **CHK**
  - Byte == `sum`: -> HOLD, `frame_valid`<=1, `frame_len`<=L.
  - Otherwise: pulse `err_chk`, -> IDLE. Buffer contents are don't-care.
- **HOLD**
  - `frame_ack` -> IDLE, `frame_valid`<=0.
  - An `rx_done` in HOLD is dropped and pulses `err_overrun`, including a header byte.
  - `rx_done` and `frame_ack` in the same cycle: the ack takes effect and the byte is dropped with `err_overrun`.
  - `frame_ack` outside HOLD is ignored.

Timeout:
- A 16-bit counter runs in LEN, PAYLOAD and CHK.
- It clears on every `rx_done` and on entry to those states.
- Reaching `TIMEOUT_CYC` with no byte: pulse `err_timeout`, -> IDLE.
- If `rx_done` and the timeout coincide, the byte wins and the counter clears.
- No timeout applies in IDLE or HOLD.

Arithmetic and reads:
- The checksum covers the length byte and the payload; the header is excluded. All sums are 8-bit modulo 256.
- `rd_addr` >= `frame_len` returns 8'h00.
- Reads are legal only in HOLD; outside HOLD `rd_data` is undefined.

## Timing
Reset values:
- FSM = IDLE.
- `frame_valid`=0, `frame_len`=0, `rd_data`=0, `busy`=0.
- All `err_*`=0; timeout counter=0, `idx`=0, `sum`=0.
- Buffer contents are not reset.

Latencies:
- `rx_done` of the checksum byte at cycle N -> `frame_valid`=1 at N+1.
- The `err_*` pulse for a bad byte at cycle N occurs at N+1, exactly one cycle wide.
- `rd_data` = `buf[rd_addr]` one cycle after `rd_addr` is applied.
- `frame_ack` at cycle N -> `frame_valid`=0 at N+1. A header arriving at N+1 or later starts a new frame.
- `busy` follows the registered state.

`rst` mid-frame or in HOLD:
- Immediately forces IDLE with all outputs at reset values.
- Any partial or held frame is lost, and no error pulse is emitted.

## Test plan
- **Good frame:** A5 03 11 22 33 69 -> `frame_valid`=1 one cycle after the last `rx_done`, `frame_len`=3. Reading `rd_addr` 0/1/2 gives 11/22/33. `frame_ack` -> `frame_valid`=0.
- **Bad checksum:** A5 02 10 20 00 -> single `err_chk` pulse, `frame_valid` stays 0, FSM returns to IDLE. Then the good frame A5 01 7F 80 is accepted.
- **Length error:** A5 00, and A5 with L=`MAX_LEN`+1 -> one `err_len` pulse each, back to IDLE. Maximum length L=16 with the correct sum is accepted.
- **Timeout:** A5 04 01, then silence for `TIMEOUT_CYC` cycles -> `err_timeout` pulse. A following complete frame is accepted normally. A gap of `TIMEOUT_CYC`-1 cycles causes no timeout.
- **Overrun and ack collision:**
  - Deliver bytes A5 01 55 56 while a frame is held -> four `err_overrun` pulses; the held data is unchanged.
  - `frame_ack` in the same cycle as `rx_done` -> ack honored, byte dropped with `err_overrun`.
- **Reset mid-frame:** assert `rst` after A5 03 11 -> all outputs 0 and `busy`=0. Bytes 22 33 69 then produce no frame and no errors; a fresh good frame is accepted.
